// File: rtl/mmap_irq_ctrl.sv
// -----------------------------------------------------------------------------
// mmap_irq_ctrl
//   Memory-mapped interrupt controller. Synchronizes IRQ_NUM asynchronous
//   interrupt lines. Each source is either edge- or level-triggered, and the
//   enabled pending sources are combined into one registered interrupt output.
//   A claim register returns the lowest-numbered active source.
//
//   Register window (256 bytes at BASE_ADDR), word offsets:
//     0x00 ENABLE  RW      0x04 PENDING R/W1C   0x08 TRIG RW (1=edge, 0=level)
//     0x0C CLAIM   RO      0x10 RAW     RO (synchronized irq_i)
//
// Ports
//   clk_i          system clock
//   rst_i          asynchronous active-high reset
//   mmap_valid_i   bus request valid, held until mmap_ready_o
//   mmap_addr_i    byte address
//   mmap_wdata_i   write data
//   mmap_wstrb_i   byte strobes, 4'h0 = read
//   mmap_rdata_o   read data, valid while mmap_ready_o=1
//   mmap_ready_o   single-cycle completion pulse
//   irq_i          asynchronous interrupt lines, active-high
//   irq_o          aggregated interrupt, registered, active-high
// -----------------------------------------------------------------------------
module mmap_irq_ctrl #(
    parameter int unsigned IRQ_NUM   = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mmap_valid_i,
    input  logic [31:0]        mmap_addr_i,
    input  logic [31:0]        mmap_wdata_i,
    input  logic [3:0]         mmap_wstrb_i,
    output logic [31:0]        mmap_rdata_o,
    output logic               mmap_ready_o,
    input  logic [IRQ_NUM-1:0] irq_i,
    output logic               irq_o
);

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    localparam logic [5:0] OFF_ENABLE  = 6'h00;
    localparam logic [5:0] OFF_PENDING = 6'h01;
    localparam logic [5:0] OFF_TRIG    = 6'h02;
    localparam logic [5:0] OFF_CLAIM   = 6'h03;
    localparam logic [5:0] OFF_RAW     = 6'h04;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [IRQ_NUM-1:0] r_sync1;
    logic [IRQ_NUM-1:0] r_sync2;
    logic [IRQ_NUM-1:0] r_sync_d;
    logic [2:0]         r_vld;
    logic [IRQ_NUM-1:0] r_en;
    logic [IRQ_NUM-1:0] r_trig;
    logic [IRQ_NUM-1:0] r_pend;
    logic [31:0]        r_rdata;
    logic               r_irq;

    logic               w_hit;
    logic               w_take;
    logic               w_wr;
    logic               w_rd;
    logic [5:0]         w_word;
    logic [31:0]        w_mask32;
    logic [IRQ_NUM-1:0] w_wmask;
    logic [IRQ_NUM-1:0] w_wdata;
    logic [IRQ_NUM-1:0] w_rise;
    logic [IRQ_NUM-1:0] w_act;
    logic [4:0]         w_claim_id;
    logic [IRQ_NUM-1:0] w_claim_oh;
    logic [IRQ_NUM-1:0] w_en_new;
    logic [IRQ_NUM-1:0] w_trig_new;
    logic [IRQ_NUM-1:0] w_w1c;
    logic [IRQ_NUM-1:0] w_clm;
    logic [IRQ_NUM-1:0] w_mode_chg;
    logic [IRQ_NUM-1:0] w_pend_nxt;
    logic [31:0]        w_rdata_nxt;
    logic               w_unused;

    // ------------------------------------------------------------------
    // Synchronizer and edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sync_d <= '0;
            r_vld    <= '0;
        end else begin
            r_sync1  <= irq_i;
            r_sync2  <= r_sync1;
            r_sync_d <= r_sync2;
            r_vld    <= {r_vld[1:0], 1'b1};
        end
    end

    // r_vld[2] marks that r_sync_d holds a real sample rather than its reset
    // value, so a line already high during reset does not look like an edge.
    assign w_rise = r_sync2 & ~r_sync_d & {IRQ_NUM{r_vld[2]}};

    // ------------------------------------------------------------------
    // Claim priority encoder: lowest active source wins, id = n + 1
    // ------------------------------------------------------------------
    assign w_act = r_pend & r_en;

    always_comb begin
        w_claim_id = '0;
        for (int unsigned i = IRQ_NUM; i > 0; i--) begin
            if (w_act[i-1]) begin
                w_claim_id = 5'(i);
            end
        end
    end

    always_comb begin
        w_claim_oh = '0;
        for (int unsigned i = 0; i < IRQ_NUM; i++) begin
            w_claim_oh[i] = (w_claim_id == 5'(i + 1));
        end
    end

    // ------------------------------------------------------------------
    // Bus decode; all side effects happen only on the IDLE->ACK step
    // ------------------------------------------------------------------
    assign w_hit   = mmap_valid_i & (mmap_addr_i[31:8] == BASE_ADDR[31:8]);
    assign w_take  = (r_state == S_IDLE) & w_hit;
    assign w_wr    = w_take & (|mmap_wstrb_i);
    assign w_rd    = w_take & ~(|mmap_wstrb_i);
    assign w_word  = mmap_addr_i[7:2];

    assign w_mask32 = {{8{mmap_wstrb_i[3]}}, {8{mmap_wstrb_i[2]}},
                       {8{mmap_wstrb_i[1]}}, {8{mmap_wstrb_i[0]}}};
    assign w_wmask  = w_mask32[IRQ_NUM-1:0];
    assign w_wdata  = mmap_wdata_i[IRQ_NUM-1:0];

    assign w_unused = ^{mmap_addr_i[1:0], mmap_wdata_i[31:IRQ_NUM],
                        w_mask32[31:IRQ_NUM]};

    assign w_en_new   = (r_en   & ~w_wmask) | (w_wdata & w_wmask);
    assign w_trig_new = (r_trig & ~w_wmask) | (w_wdata & w_wmask);

    assign w_w1c      = (w_wr && w_word == OFF_PENDING) ? (w_wdata & w_wmask) : '0;
    assign w_clm      = (w_rd && w_word == OFF_CLAIM)   ? w_claim_oh          : '0;
    assign w_mode_chg = (w_wr && w_word == OFF_TRIG)    ? (w_trig_new ^ r_trig) : '0;

    // ------------------------------------------------------------------
    // Pending next state: edge sources latch rises (set beats clear),
    // level sources mirror the synchronized line; a mode change clears.
    // ------------------------------------------------------------------
    always_comb begin
        w_pend_nxt = r_pend;
        for (int unsigned i = 0; i < IRQ_NUM; i++) begin
            if (r_trig[i]) begin
                w_pend_nxt[i] = (r_pend[i] & ~(w_w1c[i] | w_clm[i])) | w_rise[i];
            end else begin
                w_pend_nxt[i] = r_sync2[i];
            end
            if (w_mode_chg[i]) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read data mux (latched on the IDLE->ACK step)
    // ------------------------------------------------------------------
    always_comb begin
        w_rdata_nxt = '0;
        if (w_rd) begin
            case (w_word)
                OFF_ENABLE:  w_rdata_nxt[IRQ_NUM-1:0] = r_en;
                OFF_PENDING: w_rdata_nxt[IRQ_NUM-1:0] = r_pend;
                OFF_TRIG:    w_rdata_nxt[IRQ_NUM-1:0] = r_trig;
                OFF_CLAIM:   w_rdata_nxt[4:0]         = w_claim_id;
                OFF_RAW:     w_rdata_nxt[IRQ_NUM-1:0] = r_sync2;
                default:     w_rdata_nxt              = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_en    <= '0;
            r_trig  <= '0;
            r_pend  <= '0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_irq  <= |(r_pend & r_en);
            if (w_wr && w_word == OFF_ENABLE) begin
                r_en <= w_en_new;
            end
            if (w_wr && w_word == OFF_TRIG) begin
                r_trig <= w_trig_new;
            end
            if (w_take) begin
                r_rdata <= w_rdata_nxt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hit) w_state_nxt = S_ACK;
            S_ACK:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign mmap_ready_o = (r_state == S_ACK);
    assign mmap_rdata_o = r_rdata;
    assign irq_o        = r_irq;

endmodule

// File: doc/mmap_irq_ctrl.md
MMAP_IRQ_CTRL -- requirements
Module: mmap_irq_ctrl

Interface
REQ-001 SHALL have parameter IRQ_NUM, default 6, number of interrupt sources (1..31).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0300_0000, 256-byte register window base.
REQ-003 SHALL be single-clock with asynchronous, active-high reset: one clock; reset is asynchronous and active-high.
REQ-004 clk_i  input  1  system clock.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 mmap_valid_i  input  1  bus request valid; held until mmap_ready_o.
REQ-007 mmap_addr_i  input  32  byte address.
REQ-008 mmap_wdata_i  input  32  write data.
REQ-009 mmap_wstrb_i  input  4  byte strobes; 4'h0 = read.
REQ-010 mmap_rdata_o  output  32  read data, valid while mmap_ready_o=1.
REQ-011 mmap_ready_o  output  1  single-cycle completion pulse.
REQ-012 irq_i  input  IRQ_NUM  asynchronous peripheral interrupt lines, active-high.
REQ-013 irq_o  output  1  aggregated interrupt to CPU, registered, active-high.

Function
REQ-014 irq_i SHALL pass a 2-flop synchronizer; sync[n] is the synchronized value.
REQ-015 Edge detect SHALL use a third flop; rise[n] = sync[n] & ~sync_d[n].
REQ-016 Register map (offset, word): 0x00 ENABLE RW; 0x04 PENDING R/W1C; 0x08 TRIG RW (1=rising edge, 0=level); 0x0C CLAIM RO; 0x10 RAW RO (sync).
REQ-017 Only bits [IRQ_NUM-1:0] SHALL be implemented; the upper bits read 0 and writes to them are ignored.
REQ-018 Edge mode: pend[n] SHALL set on rise[n] and clear on a PENDING write with wdata[n]=1, or on a CLAIM read returning n+1.
REQ-019 Level mode: pend[n] SHALL equal sync[n] each cycle; W1C and claim have no effect.
REQ-020 Set SHALL win over clear: rise[n] in the same cycle as W1C or claim of n leaves pend[n]=1.
REQ-021 Writing TRIG SHALL clear pend bits of any source whose mode changes.
REQ-022 CLAIM read SHALL return (lowest n with pend[n]&en[n]) + 1, or 0 if none.
REQ-023 irq_o SHALL be registered: irq_o <= |(pend & en); latency rise-to-irq_o = 4 clk (2 sync, 1 edge/pend, 1 out).
REQ-024 Bus decode: hit = mmap_valid_i & (mmap_addr_i[31:8] == BASE_ADDR[31:8]); a non-hit SHALL never assert mmap_ready_o.
REQ-025 FSM states IDLE and ACK; IDLE->ACK on hit; ACK->IDLE unconditionally; mmap_ready_o=1 only in ACK.
REQ-026 Register side effects (write, W1C, claim clear) SHALL occur exactly once, on the IDLE->ACK transition; read data SHALL be latched on that transition.
REQ-027 A request present during ACK SHALL NOT be sampled; it is handled after the return to IDLE (2-cycle minimum per access).
REQ-028 Writes SHALL honour byte strobes on ENABLE/TRIG/PENDING; CLAIM/RAW writes ignored.
REQ-029 Unmapped offsets within the window SHALL read 0, ignore writes, and still complete with ready.

Reset
REQ-030 On rst_i=1, asynchronously: ENABLE=0, TRIG=0, pend=0, sync/edge flops=0, FSM=IDLE, mmap_ready_o=0, mmap_rdata_o=0, irq_o=0.
REQ-031 Reset asserted mid-access SHALL abort it; no ready pulse is issued for the aborted request after release.
REQ-032 The first cycle after release SHALL NOT detect a false edge on an irq_i already high at reset.

Verification
REQ-033 Write ENABLE=0x3F, TRIG=0x01; pulse irq_i[0] high for 3 clk -> PENDING reads 0x01, irq_o=1 four clk after rise, CLAIM reads 1, then PENDING=0 and irq_o=0.
REQ-034 Edges on irq_i[2] and irq_i[4] in edge mode -> CLAIM returns 3, then 5, then 0.
REQ-035 Level mode source 1 held high, W1C 0x02 -> PENDING stays 0x02; drop irq_i[1] -> PENDING=0 three clk later.
REQ-036 W1C of bit 0 in the same cycle as rise[0] -> pend[0] remains 1.
REQ-037 Read offset 0x40 -> rdata 0, ready pulses once; address outside the window -> no ready within 16 clk.
REQ-038 Assert rst_i during ACK with irq_i=0x3F -> all outputs 0; after release, no edge pend, irq_o=0.
